p_mem_wb_stage: RTL and testbench
=================================

Name: p_mem_wb_stage

Overview:
- MEM stage of the RV32IM pipeline, directly downstream of the EX/MEM stage; consumes its control, ALU result, store data, rd and funct3.
- Drives a variable-latency req/ack data-memory port and formats loads and stores by funct3.
- Stalls upstream while an access is outstanding.
- Registers the write-back result into the MEM/WB pipeline register for the WB stage and the forwarding unit.

Parameters:
WIDTH, 32, data/address width
ACK_TIMEOUT, 255, max cycles waiting for i_dmem_ack before bus error (8-bit counter)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-low reset
en  in  1  pipeline advance enable from hazard unit; must not depend combinationally on o_stall
i_reg_write_en  in  1  rd write enable
i_dm_write_en  in  1  store
i_dm_read_en  in  1  load
i_wb_sel  in  2  00 ALU, 01 MEM, 10 PC+4, 11 ALU
i_pc_plus_4  in  32  link value
i_alu_result  in  32  effective address / ALU value
i_rs2_data  in  32  store data
i_rd_addr  in  5  destination register
i_funct3  in  3  access size/sign
i_debug_inst  in  32  debug instruction tag
o_dmem_req  out  1  memory request
o_dmem_we  out  1  write request
o_dmem_addr  out  32  word-aligned address ({addr[31:2],2'b00})
o_dmem_wdata  out  32  lane-replicated store data
o_dmem_be  out  4  byte enables
i_dmem_rdata  in  32  read word
i_dmem_ack  in  1  access complete (may arrive in the request cycle)
o_stall  out  1  freeze IF..EX/MEM
o_reg_write_en  out  1  registered rd write enable
o_rd_addr  out  5  registered rd
o_rd_data  out  32  registered write-back value
o_exc  out  1  registered exception: misaligned / illegal funct3 / bus error
o_exc_cause  out  2  01 misaligned, 10 illegal funct3, 11 bus timeout
o_debug_inst  out  32  registered debug tag

Behaviour:
- Reset (rst=0 at clk edge): all registered outputs 0, FSM IDLE, timeout counter 0. Combinational bus outputs follow FSM, so o_dmem_req=0 during reset. Reset mid-access drops req; a late ack in IDLE is ignored.
- access = i_dm_read_en | i_dm_write_en. If both are set, treat as store.
- Formatting by funct3:
  - 000 B: be=0001<<a[1:0].
  - 001 H: be=0011<<{a[1],1'b0}; misaligned if a[0].
  - 010 W: be=1111; misaligned if a[1:0]!=0.
  - 100 BU, 101 HU: loads only, same alignment rules as B/H.
  - Any other funct3 on an access is illegal.
  - Stores: wdata = byte x4 / half x2 / word.
  - Loads: select the lane by a[1:0], sign- or zero-extend.
- Faulting access (misaligned or illegal): no request issued, no stall. On the en edge the register loads o_exc=1 with the cause, o_reg_write_en=0 and o_rd_data=0.
- FSM:
  - IDLE: if access and no fault, o_dmem_req=1 combinationally.
    - ack in the same cycle: completes, o_stall=0; if en=0, go HELD.
    - no ack: go WAIT, o_stall=1.
  - WAIT: req held with stable addr/we/be/wdata; o_stall=1; counter increments.
    - On ack: o_stall=0 that cycle; result loads if en=1 (to IDLE), else to HELD.
    - If the counter reaches ACK_TIMEOUT: drop req, complete with cause 11, rd write suppressed.
  - HELD: formatted load data is buffered, req=0, o_stall=0. When en=1, load the MEM/WB register from the buffer and go IDLE.
- No access: the pipeline register loads on en=1 with zero extra latency.
  - o_rd_data = ALU (wb_sel 00/11), formatted load (01), or pc+4 (10).
  - o_reg_write_en = i_reg_write_en & ~fault.
  - o_rd_addr and o_debug_inst pass through.
- en=0 holds all registered outputs. o_stall never depends on en.
- Latency: a non-memory or same-cycle-ack instruction reaches the MEM/WB register 1 cycle after it enters this stage. An N-cycle ack adds N-1 stall cycles.

Decomposition:
- Shared package rv32i_decoder_header.vh holds the constants:
  - funct3 load/store codes
  - wb_sel encodings
  - exception cause codes
  - FSM state typedef {IDLE, WAIT, HELD}
- One sub-module, rv32i_lsu_align (combinational): byte enables, store replication, load extraction/extension, fault detect.
- The FSM, counter and pipeline register live in the top module.

Test Plan:
- ALU op: wb_sel=00, alu=0x1234, rd=5, en=1 -> next cycle o_rd_data=0x1234, o_reg_write_en=1, o_rd_addr=5, no req.
- LB, addr 0x103, rdata 0x80FF_0000, ack same cycle -> o_dmem_addr=0x100, be=1000, o_stall=0, o_rd_data=0xFFFFFF80. LBU on the same access gives 0x80.
- SH, addr 0x202, rs2=0xABCD1234, ack after 3 cycles -> be=1100, wdata=0x12341234, o_stall high exactly 2 cycles, o_reg_write_en=0.
- LW, addr 0x101 -> no req, o_exc=1, cause 01, o_reg_write_en=0. LB with funct3=011 -> cause 10.
- LW, ack arrives while en=0 -> HELD, req drops, o_rd_data unchanged until en=1, then data appears. Further acks are ignored.
- LW, no ack for 255 cycles -> req drops, o_exc=1, cause 11. Separately, rst=0 mid-WAIT -> req=0 and all outputs 0 next cycle.

Source files
------------

// File: rtl/p_mem_wb_stage_pkg.sv
// Shared constants and types for the MEM/WB stage: funct3 access codes,
// write-back select, exception causes and the memory-access FSM state.
package p_mem_wb_stage_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] WB_ALU  = 2'b00;
  localparam logic [1:0] WB_MEM  = 2'b01;
  localparam logic [1:0] WB_PC4  = 2'b10;
  localparam logic [1:0] WB_ALU2 = 2'b11;

  localparam logic [1:0] EXC_NONE     = 2'b00;
  localparam logic [1:0] EXC_MISALIGN = 2'b01;
  localparam logic [1:0] EXC_ILLEGAL  = 2'b10;
  localparam logic [1:0] EXC_BUS      = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_WAIT = 2'b01,
    S_HELD = 2'b10
  } mem_state_e;

  // The whole FSM state (phase plus ack-wait counter) lives in one struct so
  // checkers can bind to a single signal.
  typedef struct packed {
    mem_state_e state;
    logic [7:0] cnt;
  } mem_fsm_t;

endpackage

// File: rtl/p_mem_wb_stage_lsu_align.sv
// Combinational load/store lane logic: byte enables, store replication,
// load extraction with sign/zero extension, and misaligned/illegal detection.
module rv32i_lsu_align
  import p_mem_wb_stage_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic        is_store,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic        misaligned,
  output logic        illegal
);

  logic [31:0] shifted;

  assign shifted = rdata >> {addr_lo, 3'b000};

  always_comb begin
    be         = 4'b0000;
    wdata      = store_data;
    load_data  = '0;
    misaligned = 1'b0;
    illegal    = 1'b0;
    case (funct3)
      F3_B, F3_BU: begin
        be        = 4'b0001 << addr_lo;
        wdata     = {4{store_data[7:0]}};
        load_data = (funct3 == F3_B) ? {{24{shifted[7]}}, shifted[7:0]}
                                     : {24'h0, shifted[7:0]};
        // Unsigned variants exist only for loads.
        illegal   = is_store && (funct3 == F3_BU);
      end
      F3_H, F3_HU: begin
        be         = 4'b0011 << {addr_lo[1], 1'b0};
        wdata      = {2{store_data[15:0]}};
        load_data  = (funct3 == F3_H) ? {{16{shifted[15]}}, shifted[15:0]}
                                      : {16'h0, shifted[15:0]};
        misaligned = addr_lo[0];
        illegal    = is_store && (funct3 == F3_HU);
      end
      F3_W: begin
        be         = 4'b1111;
        wdata      = store_data;
        load_data  = shifted;
        misaligned = (addr_lo != 2'b00);
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/p_mem_wb_stage.sv
// RV32IM MEM stage: drives the req/ack data-memory port, stalls upstream while
// an access is outstanding, and registers the write-back result into MEM/WB.
module p_mem_wb_stage
  import p_mem_wb_stage_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             i_reg_write_en,
  input  logic             i_dm_write_en,
  input  logic             i_dm_read_en,
  input  logic [1:0]       i_wb_sel,
  input  logic [WIDTH-1:0] i_pc_plus_4,
  input  logic [WIDTH-1:0] i_alu_result,
  input  logic [WIDTH-1:0] i_rs2_data,
  input  logic [4:0]       i_rd_addr,
  input  logic [2:0]       i_funct3,
  input  logic [WIDTH-1:0] i_debug_inst,
  output logic             o_dmem_req,
  output logic             o_dmem_we,
  output logic [WIDTH-1:0] o_dmem_addr,
  output logic [WIDTH-1:0] o_dmem_wdata,
  output logic [3:0]       o_dmem_be,
  input  logic [WIDTH-1:0] i_dmem_rdata,
  input  logic             i_dmem_ack,
  output logic             o_stall,
  output logic             o_reg_write_en,
  output logic [4:0]       o_rd_addr,
  output logic [WIDTH-1:0] o_rd_data,
  output logic             o_exc,
  output logic [1:0]       o_exc_cause,
  output logic [WIDTH-1:0] o_debug_inst
);

  // Handshake: req stays high with addr/we/be/wdata stable until the cycle in
  // which ack is seen (ack may coincide with the first req cycle, and the
  // access completes in that cycle); ack while req is low is ignored.

  logic             access, is_store, misaligned, illegal, fault;
  logic             req, stall, done, bus_err, timeout;
  logic [WIDTH-1:0] load_data, load_val, wb_val, held_data;
  logic             held_err;
  mem_fsm_t         fsm_q, fsm_d;

  assign access   = i_dm_read_en | i_dm_write_en;
  assign is_store = i_dm_write_en;
  assign fault    = access & (misaligned | illegal);
  assign timeout  = (fsm_q.state == S_WAIT) && (fsm_q.cnt == 8'(ACK_TIMEOUT));

  rv32i_lsu_align u_align (
    .funct3     (i_funct3),
    .addr_lo    (i_alu_result[1:0]),
    .is_store   (is_store),
    .store_data (i_rs2_data),
    .rdata      (i_dmem_rdata),
    .be         (o_dmem_be),
    .wdata      (o_dmem_wdata),
    .load_data  (load_data),
    .misaligned (misaligned),
    .illegal    (illegal)
  );

  always_comb begin
    fsm_d   = fsm_q;
    req     = 1'b0;
    stall   = 1'b0;
    done    = 1'b0;
    bus_err = 1'b0;
    case (fsm_q.state)
      S_IDLE: begin
        if (access && !fault) begin
          req = 1'b1;
          if (i_dmem_ack) begin
            done = 1'b1;
            if (!en) fsm_d.state = S_HELD;
          end else begin
            stall       = 1'b1;
            fsm_d.state = S_WAIT;
            fsm_d.cnt   = 8'd1;
          end
        end else begin
          done = 1'b1;
        end
      end
      S_WAIT: begin
        if (timeout) begin
          done        = 1'b1;
          bus_err     = 1'b1;
          fsm_d.state = en ? S_IDLE : S_HELD;
          fsm_d.cnt   = 8'd0;
        end else begin
          req = 1'b1;
          if (i_dmem_ack) begin
            done        = 1'b1;
            fsm_d.state = en ? S_IDLE : S_HELD;
            fsm_d.cnt   = 8'd0;
          end else begin
            stall     = 1'b1;
            fsm_d.cnt = fsm_q.cnt + 8'd1;
          end
        end
      end
      S_HELD: begin
        done    = 1'b1;
        bus_err = held_err;
        if (en) fsm_d.state = S_IDLE;
      end
      default: fsm_d = '{state: S_IDLE, cnt: 8'd0};
    endcase
  end

  assign o_dmem_req  = req & rst;
  assign o_dmem_we   = o_dmem_req & is_store;
  assign o_stall     = stall & rst;
  assign o_dmem_addr = {i_alu_result[WIDTH-1:2], 2'b00};

  assign load_val = (fsm_q.state == S_HELD) ? held_data : load_data;

  always_comb begin
    case (i_wb_sel)
      WB_MEM:  wb_val = load_val;
      WB_PC4:  wb_val = i_pc_plus_4;
      default: wb_val = i_alu_result;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      fsm_q     <= '{state: S_IDLE, cnt: 8'd0};
      held_data <= '0;
      held_err  <= 1'b0;
    end else begin
      fsm_q <= fsm_d;
      // Memory drops rdata after ack, so the formatted word is kept for HELD.
      if (fsm_q.state != S_HELD && fsm_d.state == S_HELD) begin
        held_data <= load_data;
        held_err  <= bus_err;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      o_reg_write_en <= 1'b0;
      o_rd_addr      <= '0;
      o_rd_data      <= '0;
      o_exc          <= 1'b0;
      o_exc_cause    <= EXC_NONE;
      o_debug_inst   <= '0;
    end else if (en) begin
      if (!done) begin
        // Access still outstanding: hand WB a bubble.
        o_reg_write_en <= 1'b0;
        o_rd_addr      <= '0;
        o_rd_data      <= '0;
        o_exc          <= 1'b0;
        o_exc_cause    <= EXC_NONE;
        o_debug_inst   <= '0;
      end else if (fault || bus_err) begin
        o_reg_write_en <= 1'b0;
        o_rd_addr      <= i_rd_addr;
        o_rd_data      <= '0;
        o_exc          <= 1'b1;
        o_exc_cause    <= bus_err ? EXC_BUS :
                          (misaligned ? EXC_MISALIGN : EXC_ILLEGAL);
        o_debug_inst   <= i_debug_inst;
      end else begin
        o_reg_write_en <= i_reg_write_en;
        o_rd_addr      <= i_rd_addr;
        o_rd_data      <= wb_val;
        o_exc          <= 1'b0;
        o_exc_cause    <= EXC_NONE;
        o_debug_inst   <= i_debug_inst;
      end
    end
  end

endmodule

// File: tb/tb_p_mem_wb_stage.sv
// Directed testbench for p_mem_wb_stage: ALU pass-through, load/store
// formatting, variable-latency acks, faults, HELD buffering, timeout, reset.
module tb_p_mem_wb_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        i_reg_write_en, i_dm_write_en, i_dm_read_en;
  logic [1:0]  i_wb_sel;
  logic [31:0] i_pc_plus_4, i_alu_result, i_rs2_data, i_debug_inst;
  logic [4:0]  i_rd_addr;
  logic [2:0]  i_funct3;
  logic        o_dmem_req, o_dmem_we;
  logic [31:0] o_dmem_addr, o_dmem_wdata;
  logic [3:0]  o_dmem_be;
  logic [31:0] i_dmem_rdata;
  logic        i_dmem_ack;
  logic        o_stall, o_reg_write_en, o_exc;
  logic [4:0]  o_rd_addr;
  logic [31:0] o_rd_data, o_debug_inst;
  logic [1:0]  o_exc_cause;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q[$];

  p_mem_wb_stage #(.WIDTH(32), .ACK_TIMEOUT(255)) dut (
    .clk(clk), .rst(rst), .en(en),
    .i_reg_write_en(i_reg_write_en), .i_dm_write_en(i_dm_write_en),
    .i_dm_read_en(i_dm_read_en), .i_wb_sel(i_wb_sel),
    .i_pc_plus_4(i_pc_plus_4), .i_alu_result(i_alu_result),
    .i_rs2_data(i_rs2_data), .i_rd_addr(i_rd_addr), .i_funct3(i_funct3),
    .i_debug_inst(i_debug_inst),
    .o_dmem_req(o_dmem_req), .o_dmem_we(o_dmem_we), .o_dmem_addr(o_dmem_addr),
    .o_dmem_wdata(o_dmem_wdata), .o_dmem_be(o_dmem_be),
    .i_dmem_rdata(i_dmem_rdata), .i_dmem_ack(i_dmem_ack),
    .o_stall(o_stall), .o_reg_write_en(o_reg_write_en), .o_rd_addr(o_rd_addr),
    .o_rd_data(o_rd_data), .o_exc(o_exc), .o_exc_cause(o_exc_cause),
    .o_debug_inst(o_debug_inst)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // Checking
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Drivers
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    i_reg_write_en = 1'b0;
    i_dm_write_en  = 1'b0;
    i_dm_read_en   = 1'b0;
    i_wb_sel       = 2'b00;
    i_pc_plus_4    = 32'h0;
    i_alu_result   = 32'h0;
    i_rs2_data     = 32'h0;
    i_rd_addr      = 5'd0;
    i_funct3       = 3'b000;
    i_debug_inst   = 32'h0;
    i_dmem_rdata   = 32'h0;
    i_dmem_ack     = 1'b0;
  endtask

  task automatic drive_op(input logic rd_en, input logic wr_en, input logic rwe,
                          input logic [1:0] wb, input logic [2:0] f3,
                          input logic [31:0] alu, input logic [31:0] rs2,
                          input logic [4:0] rd, input logic [31:0] dbg);
    i_dm_read_en   = rd_en;
    i_dm_write_en  = wr_en;
    i_reg_write_en = rwe;
    i_wb_sel       = wb;
    i_funct3       = f3;
    i_alu_result   = alu;
    i_rs2_data     = rs2;
    i_rd_addr      = rd;
    i_debug_inst   = dbg;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_we"},    {31'h0, o_reg_write_en}, 32'h0);
    check({tag, "_rd"},    {27'h0, o_rd_addr}, 32'h0);
    check({tag, "_data"},  o_rd_data, 32'h0);
    check({tag, "_exc"},   {29'h0, o_exc, o_exc_cause}, 32'h0);
    check({tag, "_dbg"},   o_debug_inst, 32'h0);
    check({tag, "_req"},   {31'h0, o_dmem_req}, 32'h0);
    check({tag, "_stall"}, {31'h0, o_stall}, 32'h0);
  endtask

  // Load vectors on rdata 0x80FF0000: {funct3, addr, be, expected}
  logic [2:0]  ld_f3  [6] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010, 3'b000};
  logic [31:0] ld_addr[6] = '{32'h103, 32'h103, 32'h102, 32'h102, 32'h100, 32'h102};
  logic [3:0]  ld_be  [6] = '{4'b1000, 4'b1000, 4'b1100, 4'b1100, 4'b1111, 4'b0100};
  logic [31:0] ld_exp [6] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF,
                              32'h000080FF, 32'h80FF0000, 32'hFFFFFFFF};

  // Fault vectors: {rd_en, wr_en, funct3, addr, cause}
  logic        f_rd   [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
  logic [2:0]  f_f3   [4] = '{3'b010, 3'b011, 3'b100, 3'b001};
  logic [31:0] f_addr [4] = '{32'h101, 32'h100, 32'h100, 32'h203};
  logic [1:0]  f_cause[4] = '{2'b01, 2'b10, 2'b10, 2'b01};

  initial begin
    int stall_cnt;
    int req_cnt;
    logic [31:0] exp_v;
    logic [31:0] wb_vals[4] = '{32'h11, 32'h22, 32'h33, 32'h44};
    logic [1:0]  wb_sels[4] = '{2'b00, 2'b10, 2'b11, 2'b00};

    // Reset
    rst = 1'b0;
    en  = 1'b1;
    set_idle();
    tick();
    tick();
    check_outputs_zero("reset");
    rst = 1'b1;

    // ALU pass-through
    drive_op(1'b0, 1'b0, 1'b1, 2'b00, 3'b000, 32'h1234, 32'h0, 5'd5, 32'hA1);
    #1;
    check("alu_req", {31'h0, o_dmem_req}, 32'h0);
    tick();
    check("alu_data", o_rd_data, 32'h1234);
    check("alu_we", {31'h0, o_reg_write_en}, 32'h1);
    check("alu_rd", {27'h0, o_rd_addr}, 32'd5);
    check("alu_dbg", o_debug_inst, 32'hA1);

    // en=0 holds the register
    en = 1'b0;
    drive_op(1'b0, 1'b0, 1'b1, 2'b00, 3'b000, 32'h9999, 32'h0, 5'd6, 32'hA2);
    tick();
    check("hold_data", o_rd_data, 32'h1234);
    check("hold_rd", {27'h0, o_rd_addr}, 32'd5);
    en = 1'b1;

    // Back-to-back non-memory ops with wb_sel variants, zero extra latency
    for (int i = 0; i < 4; i++) begin
      drive_op(1'b0, 1'b0, 1'b1, wb_sels[i], 3'b000, wb_vals[i], 32'h0, 5'(i + 1), 32'h0);
      i_pc_plus_4 = 32'h1000 + 32'(i);
      exp_q.push_back((wb_sels[i] == 2'b10) ? (32'h1000 + 32'(i)) : wb_vals[i]);
      tick();
      exp_v = exp_q.pop_front();
      check("stream_data", o_rd_data, exp_v);
    end

    // Loads with same-cycle ack
    for (int i = 0; i < 6; i++) begin
      drive_op(1'b1, 1'b0, 1'b1, 2'b01, ld_f3[i], ld_addr[i], 32'h0, 5'd7, 32'hB0);
      i_dmem_rdata = (i == 5) ? 32'h00FF0000 : 32'h80FF0000;
      i_dmem_ack   = 1'b1;
      #1;
      check("ld_req", {31'h0, o_dmem_req}, 32'h1);
      check("ld_we_bus", {31'h0, o_dmem_we}, 32'h0);
      check("ld_addr", o_dmem_addr, ld_addr[i] & 32'hFFFFFFFC);
      check("ld_be", {28'h0, o_dmem_be}, {28'h0, ld_be[i]});
      check("ld_stall", {31'h0, o_stall}, 32'h0);
      tick();
      check("ld_data", o_rd_data, ld_exp[i]);
      check("ld_wen", {31'h0, o_reg_write_en}, 32'h1);
      set_idle();
    end

    // SH with ack on the third request cycle
    drive_op(1'b0, 1'b1, 1'b0, 2'b00, 3'b001, 32'h202, 32'hABCD1234, 5'd0, 32'hC0);
    stall_cnt = 0;
    for (int c = 1; c <= 3; c++) begin
      i_dmem_ack = (c == 3);
      #1;
      check("sh_req", {31'h0, o_dmem_req}, 32'h1);
      check("sh_we_bus", {31'h0, o_dmem_we}, 32'h1);
      check("sh_be", {28'h0, o_dmem_be}, 32'hC);
      check("sh_wdata", o_dmem_wdata, 32'h12341234);
      check("sh_addr", o_dmem_addr, 32'h200);
      if (o_stall) stall_cnt++;
      tick();
    end
    set_idle();
    check("sh_stall_cycles", 32'(stall_cnt), 32'd2);
    check("sh_wen", {31'h0, o_reg_write_en}, 32'h0);
    check("sh_data", o_rd_data, 32'h202);
    check("sh_exc", {31'h0, o_exc}, 32'h0);

    // Faulting accesses: no request, no stall, exception registered
    for (int i = 0; i < 4; i++) begin
      drive_op(f_rd[i], ~f_rd[i], 1'b1, 2'b01, f_f3[i], f_addr[i], 32'h55, 5'd3, 32'hD0);
      i_dmem_ack = 1'b1;
      #1;
      check("flt_req", {31'h0, o_dmem_req}, 32'h0);
      check("flt_stall", {31'h0, o_stall}, 32'h0);
      tick();
      check("flt_exc", {31'h0, o_exc}, 32'h1);
      check("flt_cause", {30'h0, o_exc_cause}, {30'h0, f_cause[i]});
      check("flt_wen", {31'h0, o_reg_write_en}, 32'h0);
      check("flt_data", o_rd_data, 32'h0);
      set_idle();
    end

    // LW acked while en=0 -> HELD; data appears only once en returns
    drive_op(1'b0, 1'b0, 1'b1, 2'b00, 3'b000, 32'h5555, 32'h0, 5'd4, 32'h0);
    tick();
    check("pre_held", o_rd_data, 32'h5555);
    en = 1'b0;
    drive_op(1'b1, 1'b0, 1'b1, 2'b01, 3'b010, 32'h300, 32'h0, 5'd9, 32'hE0);
    i_dmem_rdata = 32'hDEADBEEF;
    i_dmem_ack   = 1'b1;
    #1;
    check("held_req0", {31'h0, o_dmem_req}, 32'h1);
    check("held_stall0", {31'h0, o_stall}, 32'h0);
    tick();
    i_dmem_rdata = 32'h11111111;
    for (int c = 0; c < 3; c++) begin
      #1;
      check("held_req", {31'h0, o_dmem_req}, 32'h0);
      check("held_stall", {31'h0, o_stall}, 32'h0);
      check("held_keep", o_rd_data, 32'h5555);
      tick();
    end
    en = 1'b1;
    tick();
    set_idle();
    check("held_data", o_rd_data, 32'hDEADBEEF);
    check("held_rd", {27'h0, o_rd_addr}, 32'd9);
    check("held_wen", {31'h0, o_reg_write_en}, 32'h1);
    #1;
    check("after_held_req", {31'h0, o_dmem_req}, 32'h0);

    // LW with no ack -> bus timeout after 255 request cycles
    drive_op(1'b1, 1'b0, 1'b1, 2'b01, 3'b010, 32'h400, 32'h0, 5'd10, 32'hF0);
    req_cnt = 0;
    for (int c = 0; c < 300; c++) begin
      #1;
      if (!o_dmem_req) break;
      req_cnt++;
      tick();
    end
    check("to_req_cycles", 32'(req_cnt), 32'd255);
    check("to_stall", {31'h0, o_stall}, 32'h0);
    tick();
    set_idle();
    check("to_exc", {31'h0, o_exc}, 32'h1);
    check("to_cause", {30'h0, o_exc_cause}, 32'h3);
    check("to_wen", {31'h0, o_reg_write_en}, 32'h0);
    check("to_data", o_rd_data, 32'h0);

    // Reset mid-WAIT, then a late ack in IDLE is ignored
    drive_op(1'b1, 1'b0, 1'b1, 2'b01, 3'b010, 32'h500, 32'h0, 5'd11, 32'h77);
    tick();
    tick();
    check("rw_req", {31'h0, o_dmem_req}, 32'h1);
    check("rw_stall", {31'h0, o_stall}, 32'h1);
    rst = 1'b0;
    tick();
    check_outputs_zero("rw_reset");
    set_idle();
    rst = 1'b1;
    i_dmem_ack   = 1'b1;
    i_dmem_rdata = 32'hCAFEF00D;
    drive_op(1'b0, 1'b0, 1'b1, 2'b01, 3'b000, 32'h0, 32'h0, 5'd12, 32'h0);
    #1;
    check("late_ack_req", {31'h0, o_dmem_req}, 32'h0);
    tick();
    check("late_ack_wen", {31'h0, o_reg_write_en}, 32'h1);
    check("late_ack_exc", {31'h0, o_exc}, 32'h0);
    set_idle();
    tick();

    // Report
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
